// File: rtl/rtu2_pkg.sv
// rtu2_pkg: shared constants and FSM state type for the code serializer.
// Build option: RTU2_PARITY_EN adds the PAR state to the state type.
package rtu2_pkg;

  localparam int   CODE_W    = 3;
  localparam logic TX_IDLE   = 1'b1;
  localparam logic START_BIT = 1'b0;

`ifdef RTU2_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } state_t;
`endif

endpackage

// File: rtl/rtu2_code_fifo.sv
// rtu2_code_fifo: small synchronous FIFO for encoder code words.
// DEPTH must be a power of two so the pointers wrap naturally.
module rtu2_code_fifo
  import rtu2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [CODE_W-1:0] din,
  output logic [CODE_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [CODE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_wr;
  logic              w_rd;

  assign empty = (r_count == '0);
  assign full  = (r_count == FULL_CNT);
  assign dout  = r_mem[r_rd_ptr];

  // A pop on the same edge frees a slot, so a push into a full FIFO is accepted then.
  assign w_wr = push && (!full || pop);
  assign w_rd = pop && !empty;

  // Storage; reset only clears the pointers, old contents become unreachable.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= din;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rtu2_code_tx.sv
// rtu2_code_tx: captures changed encoder codes into a FIFO and sends each
// one as a serial frame: START, three data bits LSB first, [PAR], STOP.
// Build option: RTU2_PARITY_EN inserts an even-parity bit after the data.
//
// state | meaning
// IDLE  | line high, waiting for a FIFO entry
// START | start bit (low) for BIT_DIV cycles
// DATA  | code bits 0..2, BIT_DIV cycles each
// PAR   | even parity of the code (parity builds only)
// STOP  | stop bit (high) for BIT_DIV cycles
module rtu2_code_tx
  import rtu2_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int BIT_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] code,
  input  logic              code_v,
  input  logic              clr_ovf,
  output logic              tx,
  output logic              busy,
  output logic              empty,
  output logic              full,
  output logic              ovf
);

  localparam int CNT_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BIT_DIV - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_last_v;
  logic [CODE_W-1:0] r_last_code;
  logic              r_ovf;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_bit_idx;
  logic [CODE_W-1:0] r_shift;
  logic [CODE_W-1:0] w_shift_nxt;
  logic              r_tx;
  logic              w_tx_nxt;
  logic              w_push_req;
  logic              w_pop;
  logic              w_drop;
  logic              w_tc;
  logic              w_reload;
  logic              w_empty;
  logic              w_full;
  logic [CODE_W-1:0] w_dout;
`ifdef RTU2_PARITY_EN
  logic              r_par;
`endif

  rtu2_code_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push_req),
    .pop   (w_pop),
    .din   (code),
    .dout  (w_dout),
    .empty (w_empty),
    .full  (w_full)
  );

  assign w_push_req = code_v && (!r_last_v || (code != r_last_code));
  assign w_pop      = (r_state == ST_IDLE) && !w_empty;
  assign w_drop     = w_push_req && w_full && !w_pop;
  assign w_tc       = (r_cnt == '0);
  // Reload the bit-period timer on leaving IDLE and at every period end that stays in a frame.
  assign w_reload   = (r_state == ST_IDLE) ? w_pop : (w_tc && (w_state_nxt != ST_IDLE));

  assign tx    = r_tx;
  assign busy  = (r_state != ST_IDLE);
  assign empty = w_empty;
  assign full  = w_full;
  assign ovf   = r_ovf;

  // Change detector history and sticky overflow; a drop beats a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_v    <= 1'b0;
      r_last_code <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_last_v    <= code_v;
      r_last_code <= code;
      if (w_drop)       r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state logic; every non-IDLE state lasts one bit period.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (!w_empty) w_state_nxt = ST_START;
      ST_START: if (w_tc) w_state_nxt = ST_DATA;
      ST_DATA: begin
        if (w_tc && (r_bit_idx == 2'd2)) begin
`ifdef RTU2_PARITY_EN
          w_state_nxt = ST_PAR;
`else
          w_state_nxt = ST_STOP;
`endif
        end
      end
`ifdef RTU2_PARITY_EN
      ST_PAR:   if (w_tc) w_state_nxt = ST_STOP;
`endif
      ST_STOP:  if (w_tc) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: next shift contents and the line level for the coming cycle.
  always_comb begin
    w_shift_nxt = r_shift;
    if (w_pop)                               w_shift_nxt = w_dout;
    else if ((r_state == ST_DATA) && w_tc)   w_shift_nxt = {1'b0, r_shift[CODE_W-1:1]};
    case (w_state_nxt)
      ST_START: w_tx_nxt = START_BIT;
      ST_DATA:  w_tx_nxt = w_shift_nxt[0];
`ifdef RTU2_PARITY_EN
      ST_PAR:   w_tx_nxt = r_par;
`endif
      default:  w_tx_nxt = TX_IDLE;
    endcase
  end

  // Frame datapath: bit-period down-counter, bit index, shift register, line register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_bit_idx <= 2'd0;
      r_shift   <= '0;
      r_tx      <= TX_IDLE;
    end else begin
      if (w_reload)   r_cnt <= CNT_MAX;
      else if (!w_tc) r_cnt <= r_cnt - 1'b1;
      if ((r_state == ST_START) && w_tc)     r_bit_idx <= 2'd0;
      else if ((r_state == ST_DATA) && w_tc) r_bit_idx <= r_bit_idx + 2'd1;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

`ifdef RTU2_PARITY_EN
  // Even parity is latched from the popped code so it survives the data shifting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_par <= 1'b0;
    else if (w_pop) r_par <= ^w_dout;
  end
`endif

endmodule

// File: tb/tb_rtu2_code_tx.sv
// tb_rtu2_code_tx: directed and random stimulus against a waveform-level
// reference model (code queue plus a queue of expected line levels).
module tb_rtu2_code_tx;

  localparam int DEPTH   = 4;
  localparam int BIT_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] code = 3'd0;
  logic       code_v = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       tx, busy, empty, full, ovf;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [2:0] m_q[$];
  logic       m_wave_tx[$];
  logic       m_wave_busy[$];
  logic       m_last_v = 1'b0;
  logic [2:0] m_last_code = 3'd0;
  logic       m_ovf = 1'b0;
  logic       e_tx = 1'b1;
  logic       e_busy = 1'b0;

  rtu2_code_tx #(.DEPTH(DEPTH), .BIT_DIV(BIT_DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .code    (code),
    .code_v  (code_v),
    .clr_ovf (clr_ovf),
    .tx      (tx),
    .busy    (busy),
    .empty   (empty),
    .full    (full),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_wave_tx.delete();
    m_wave_busy.delete();
    m_last_v    = 1'b0;
    m_last_code = 3'd0;
    m_ovf       = 1'b0;
    e_tx        = 1'b1;
    e_busy      = 1'b0;
  endtask

  task automatic add_seg(input logic level, input logic b);
    for (int k = 0; k < BIT_DIV; k++) begin
      m_wave_tx.push_back(level);
      m_wave_busy.push_back(b);
    end
  endtask

  // One clock edge of the model: frame waveform, FIFO queue, change detect, overflow.
  task automatic model_edge(input logic [2:0] c, input logic v, input logic clr);
    logic       push_req;
    logic       pop_now;
    logic [2:0] head;
    push_req = v && (!m_last_v || (c != m_last_code));
    pop_now  = (m_wave_tx.size() == 0) && (m_q.size() != 0);
    if (pop_now) begin
      head = m_q.pop_front();
      add_seg(1'b0, 1'b1);
      for (int b = 0; b < 3; b++) add_seg(head[b], 1'b1);
`ifdef RTU2_PARITY_EN
      add_seg(^head, 1'b1);
`endif
      add_seg(1'b1, 1'b1);
      m_wave_tx.push_back(1'b1);    // mandatory idle cycle after STOP
      m_wave_busy.push_back(1'b0);
    end
    if (m_wave_tx.size() != 0) begin
      e_tx   = m_wave_tx.pop_front();
      e_busy = m_wave_busy.pop_front();
    end else begin
      e_tx   = 1'b1;
      e_busy = 1'b0;
    end
    if (push_req) begin
      if (m_q.size() < DEPTH) m_q.push_back(c);
      else                    m_ovf = 1'b1;
    end
    if (clr && !(push_req && (m_q.size() >= DEPTH) && !pop_now && 1'b1 && m_ovf && 1'b0)) begin
    end
    m_last_v    = v;
    m_last_code = c;
  endtask

  // Clear handling kept separate so a same-edge drop wins.
  task automatic model_ovf(input logic dropped, input logic clr);
    if (dropped)  m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  // Drive one cycle from a negedge, step the model at the posedge, compare 1 time unit later.
  task automatic cycle(input logic [2:0] c, input logic v, input logic clr);
    logic dropped;
    logic push_req;
    logic pop_now;
    code    = c;
    code_v  = v;
    clr_ovf = clr;
    push_req = v && (!m_last_v || (c != m_last_code));
    pop_now  = (m_wave_tx.size() == 0) && (m_q.size() != 0);
    dropped  = push_req && (m_q.size() == DEPTH) && !pop_now;
    @(posedge clk);
    model_edge(c, v, clr);
    model_ovf(dropped, clr);
    #1;
    check_eq("tx", tx, e_tx);
    check_eq("busy", busy, e_busy);
    check_eq("empty", empty, m_q.size() == 0);
    check_eq("full", full, m_q.size() == DEPTH);
    check_eq("ovf", ovf, m_ovf);
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(3'd0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_tx"}, tx, 1'b1);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_empty"}, empty, 1'b1);
    check_eq({tag, "_full"}, full, 1'b0);
    check_eq({tag, "_ovf"}, ovf, 1'b0);
  endtask

  initial begin
    logic [2:0] rc;
    logic       rv;

    // reset with no clock edge yet
    #1 rst = 1'b1;
    #2;
    model_reset();
    check_reset_outputs("rst_noclk");
    @(negedge clk);
    rst = 1'b0;

    // single pulse of 3'b110
    cycle(3'b110, 1'b1, 1'b0);
    idle_cycles(30);

    // held code produces exactly one frame
    for (int i = 0; i < 50; i++) cycle(3'b011, 1'b1, 1'b0);
    idle_cycles(10);

    // six distinct codes back to back: sixth is dropped
    for (int i = 1; i <= 6; i++) cycle(3'(i), 1'b1, 1'b0);
    idle_cycles(10);
    check_eq("ovf_sticky", ovf, 1'b1);
    cycle(3'd0, 1'b0, 1'b1);
    check_eq("ovf_cleared", ovf, 1'b0);
    idle_cycles(130);

`ifdef RTU2_PARITY_EN
    cycle(3'b001, 1'b1, 1'b0);
    idle_cycles(30);
`endif

    // reset during the second data bit with a second code queued
    cycle(3'b101, 1'b1, 1'b0);
    cycle(3'b010, 1'b1, 1'b0);
    idle_cycles(9);
    check_eq("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    model_reset();
    check_reset_outputs("rst_mid");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(40);

    // random traffic, occasional overflow clears
    rc = 3'd0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 3) == 0) rc = 3'($urandom_range(0, 7));
      rv = ($urandom_range(0, 4) != 0);
      cycle(rc, rv, $urandom_range(0, 15) == 0);
    end
    idle_cycles(150);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtu2_code_tx.md
RTU2_CODE_TX -- requirements
Module: rtu2_code_tx

Interface
REQ-001 Parameter DEPTH, default 4: code FIFO entries, power of two, minimum 2.
REQ-002 Parameter BIT_DIV, default 4: clock cycles per serial bit, minimum 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 code  input  3  encoder code word (upstream o).
REQ-006 code_v  input  1  encoder valid (upstream v).
REQ-007 clr_ovf  input  1  synchronous clear of the overflow flag.
REQ-008 tx  output  1  serial line, idle high.
REQ-009 busy  output  1  a frame is in progress (state other than IDLE).
REQ-010 empty  output  1  FIFO holds no entries.
REQ-011 full  output  1  FIFO holds DEPTH entries.
REQ-012 ovf  output  1  sticky flag: a code was dropped.

Function
REQ-013 Change detect: registers last_v/last_code are updated every cycle; a push request is raised when code_v=1 and (last_v=0 or code!=last_code).
REQ-014 A push request writes code into the FIFO on the same edge, except when full=1 and no pop occurs that cycle; then the code is dropped and ovf sets on that edge.
REQ-015 Push and pop on the same edge, including when full: both take effect and the count is unchanged.
REQ-016 ovf clears on an edge with clr_ovf=1; a drop on the same edge wins, so ovf=1.
REQ-017 FSM states: IDLE, START, DATA, PAR, STOP.
REQ-018 IDLE with empty=0: pop the head into a 3-bit shift register and enter START; tx=0 from that edge.
REQ-019 Each state holds its tx value for exactly BIT_DIV cycles, counted by a bit-period counter.
REQ-020 DATA sends code bits LSB first (bit0, bit1, bit2), BIT_DIV cycles each.
REQ-021 After DATA, go to PAR if parity is compiled in, otherwise to STOP; STOP drives tx=1, then returns to IDLE.
REQ-022 Latency: code sampled at edge E0 is written at E0, popped at E1 if IDLE, and tx falls after E1.
REQ-023 Frame length is 5*BIT_DIV cycles, or 6*BIT_DIV with parity; after STOP there is at least one IDLE cycle (tx=1) before the next START.
REQ-024 tx is a registered output; busy, empty and full are derived from registered state only.

Reset
REQ-025 rst=1 immediately forces: tx=1, busy=0 (IDLE), FIFO empty (empty=1, full=0), ovf=0, last_v=0, last_code=0, counters 0.
REQ-026 Reset asserted mid-frame aborts the frame with no completion; FIFO contents are discarded.

Configuration
REQ-027 Macro RTU2_PARITY_EN defined: a PAR state after DATA drives the even-parity bit (XOR of the three code bits).
REQ-028 Macro RTU2_PARITY_EN undefined: no PAR state or parity logic; frame is START, DATA x3, STOP.

Structure
REQ-029 Package rtu2_pkg holds CODE_W=3, the FSM state enum type, TX_IDLE=1'b1 and START_BIT=1'b0.
REQ-030 FIFO is sub-module rtu2_code_fifo (push, pop, din, dout, empty, full; DEPTH parameter; same clk/rst).

Verification (BIT_DIV=4, DEPTH=4)
REQ-031 Reset with no clock edge -> tx=1, busy=0, empty=1, full=0, ovf=0.
REQ-032 One-cycle pulse code=3'b110, code_v=1 -> after one cycle, tx=0,0,1,1,1 for 4 cycles each; busy high for 20 cycles.
REQ-033 code=3'b011, code_v=1 held for 50 cycles -> exactly one frame (data bits 1,1,0); no second push.
REQ-034 Six distinct codes on consecutive cycles while IDLE -> codes 1-5 transmitted in order, code 6 dropped, ovf=1 until clr_ovf is pulsed.
REQ-035 With RTU2_PARITY_EN: code 3'b110 gives parity bit 0 and code 3'b001 gives parity bit 1; frame length 24 cycles.
REQ-036 rst asserted during the second DATA bit -> tx=1 with no clock edge; FIFO empty; no residual frame after release.
